// File: rtl/rom_load_ctl.sv
// Loader control for rom_dp_load: streams a base/count window into memory and
// owns port B for the duration of the load.
module rom_load_ctl #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW:0]   ld_count,
    input  logic          ld_valid,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          port_b_sel
);
    localparam logic [1:0] IDLE_CODE = 2'd0;
    localparam logic [1:0] LOAD_CODE = 2'd1;
    localparam logic [1:0] DONE_CODE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_CODE,
        LOAD = LOAD_CODE,
        DONE = DONE_CODE
    } state_e;

    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

    state_e        state_d, state_q;
    logic [AW-1:0] ptr_d, ptr_q;
    logic [AW:0]   cnt_d, cnt_q;
    logic          accept_s;

    // Next-state: a zero count leaves LOAD after one cycle; the last word ends the load.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (ld_start) begin
                    state_d = LOAD;
                    ptr_d   = ld_base;
                    cnt_d   = ld_count;
                end else begin
                    state_d = state_q;
                end
            end
            LOAD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = DONE;
                end else if (ld_valid) begin
                    accept_s = 1'b1;
                    ptr_d    = (ptr_q == PTR_LAST) ? PTR_ZERO : ptr_q + PTR_ONE;
                    cnt_d    = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PTR_ZERO;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ld_busy    = (state_q == LOAD);
    assign ld_ready   = (state_q == LOAD) && (cnt_q != CNT_ZERO);
    assign ld_done    = (state_q == DONE);
    assign wr_en      = accept_s & ~reset;
    assign wr_addr    = ptr_q;
    assign port_b_sel = ld_busy;

endmodule

// File: rtl/rom_dp_load.sv
// Dual-port block memory: read-only fetch port A, read/write port B shared with a
// run-time streaming loader.
module rom_dp_load #(
    parameter int    KB    = 1,
    parameter int    DW    = 8,
    parameter string FN    = "",
    parameter int    RO    = 1,
    localparam int   DEPTH = KB * 1024,
    localparam int   AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cea,
    input  logic [AW-1:0] aa,
    output logic [DW-1:0] qa,
    input  logic          ceb,
    input  logic          web,
    input  logic [AW-1:0] ab,
    input  logic [DW-1:0] db,
    output logic [DW-1:0] qb,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW:0]   ld_count,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done
);
    localparam logic B_WR_OK = (RO == 0);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] qa_d, qa_q, qb_d, qb_q;
    logic          ld_wr_s, port_b_sel_s, b_rd_s, b_wr_s, mem_we_s;
    logic [AW-1:0] ld_ptr_s, mem_wa_s;
    logic [DW-1:0] mem_wd_s;

    rom_load_ctl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ctl (
        .clock      (clock),
        .reset      (reset),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_count   (ld_count),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_busy    (ld_busy),
        .ld_done    (ld_done),
        .wr_en      (ld_wr_s),
        .wr_addr    (ld_ptr_s),
        .port_b_sel (port_b_sel_s)
    );

    assign b_rd_s = ceb & ~port_b_sel_s;
    assign b_wr_s = b_rd_s & web & B_WR_OK & ~reset;

    // Read ports: reads sample the array before this edge's write, so both are read-first.
    always_comb begin
        qa_d = qa_q;
        qb_d = qb_q;
        if (cea) begin
            qa_d = mem[aa];
        end else begin
            qa_d = qa_q;
        end
        if (b_rd_s) begin
            qb_d = mem[ab];
        end else begin
            qb_d = qb_q;
        end
    end

    // Single write port: the loader wins whenever it owns port B.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = ab;
        mem_wd_s = db;
        if (ld_wr_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = ld_ptr_s;
            mem_wd_s = ld_data;
        end else if (b_wr_s) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Memory array write; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem[mem_wa_s] <= mem_wd_s;
        end
    end

    // Output data registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            qa_q <= {DW{1'b0}};
            qb_q <= {DW{1'b0}};
        end else begin
            qa_q <= qa_d;
            qb_q <= qb_d;
        end
    end

    assign qa = qa_q;
    assign qb = qb_q;

endmodule

// File: tb/tb_rom_dp_load.sv
// Directed bench for rom_dp_load: RO=1 main instance plus an RO=0 instance sharing
// the loader stream; read results are checked through per-port expectation queues.
module tb_rom_dp_load;
    logic        clock = 1'b0;
    logic        reset;
    logic        cea, ceb, web, ceb2, web2;
    logic [9:0]  aa, ab, ab2, ld_base;
    logic [7:0]  db, db2, ld_data;
    logic [10:0] ld_count;
    logic        ld_start, ld_valid;
    logic [7:0]  qa, qb, qa2, qb2;
    logic        ld_ready, ld_busy, ld_done, ld_ready2, ld_busy2, ld_done2;
    logic        cea2;
    logic [9:0]  aa2;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t       qa_sb[$], qb_sb[$], qb2_sb[$];
    logic [7:0] model [1024];
    logic [7:0] ld_words[$];
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    rom_dp_load #(.KB(1), .DW(8), .FN(""), .RO(1)) dut (
        .clock(clock), .reset(reset), .cea(cea), .aa(aa), .qa(qa),
        .ceb(ceb), .web(web), .ab(ab), .db(db), .qb(qb),
        .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_busy(ld_busy), .ld_done(ld_done)
    );

    rom_dp_load #(.KB(1), .DW(8), .FN(""), .RO(0)) dut2 (
        .clock(clock), .reset(reset), .cea(cea2), .aa(aa2), .qa(qa2),
        .ceb(ceb2), .web(web2), .ab(ab2), .db(db2), .qb(qb2),
        .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready2),
        .ld_busy(ld_busy2), .ld_done(ld_done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int port, input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        if (port == 0) qa_sb.push_back(e);
        else if (port == 1) qb_sb.push_back(e);
        else qb2_sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        while (qa_sb.size() > 0) begin e = qa_sb.pop_front(); check(e.tag, {24'd0, qa}, {24'd0, e.val}); end
        while (qb_sb.size() > 0) begin e = qb_sb.pop_front(); check(e.tag, {24'd0, qb}, {24'd0, e.val}); end
        while (qb2_sb.size() > 0) begin e = qb2_sb.pop_front(); check(e.tag, {24'd0, qb2}, {24'd0, e.val}); end
    endtask

    task automatic rd_a(input string tag, input logic [9:0] addr);
        cea = 1'b1;
        aa  = addr;
        push(0, tag, model[addr]);
        tick();
        cea = 1'b0;
    endtask

    task automatic do_load(input logic [9:0] base, input logic [10:0] count, input int gap);
        ld_base  = base;
        ld_count = count;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("load_busy_start", {31'd0, ld_busy}, 32'd1);
        check("load_done_clear", {31'd0, ld_done}, 32'd0);
        for (int i = 0; i < int'(count); i++) begin
            for (int g = 0; g < gap; g++) begin
                ld_valid = 1'b0;
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = ld_words[i];
            check("load_ready", {31'd0, ld_ready}, 32'd1);
            check("load_ready2", {31'd0, ld_ready2}, 32'd1);
            tick();
            model[10'(int'(base) + i)] = ld_words[i];
        end
        ld_valid = 1'b0;
        ld_words.delete();
        check("load_end_busy", {31'd0, ld_busy}, 32'd0);
        check("load_end_done", {31'd0, ld_done}, 32'd1);
        check("load_end_done2", {31'd0, ld_done2}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        cea = 1'b0; aa = 10'd0; ceb = 1'b0; web = 1'b0; ab = 10'd0; db = 8'd0;
        cea2 = 1'b0; aa2 = 10'd0; ceb2 = 1'b0; web2 = 1'b0; ab2 = 10'd0; db2 = 8'd0;
        ld_start = 1'b0; ld_base = 10'd0; ld_count = 11'd0; ld_valid = 1'b0; ld_data = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_qa", {24'd0, qa}, 32'd0);
        check("rst_qb", {24'd0, qb}, 32'd0);
        check("rst_qa2", {24'd0, qa2}, 32'd0);
        check("rst_ready", {31'd0, ld_ready}, 32'd0);
        check("rst_busy", {31'd0, ld_busy}, 32'd0);
        check("rst_done", {31'd0, ld_done}, 32'd0);

        // Image mem[i] = i & 0xFF, written through the loader into both instances.
        for (int i = 0; i < 1024; i++) ld_words.push_back(8'(i));
        do_load(10'd0, 11'h400, 0);

        // Init read and hold.
        rd_a("init_read_3ff", 10'h3FF);
        aa = 10'd0;
        push(0, "init_hold", 8'hFF);
        tick();

        // Port B write with RO=1 ignored, RO=0 applied, both read-first.
        ceb = 1'b1; web = 1'b1; ab = 10'd5; db = 8'hAA;
        ceb2 = 1'b1; web2 = 1'b1; ab2 = 10'd5; db2 = 8'hAA;
        push(1, "ro_write_old", 8'h05);
        push(2, "rw_write_old", 8'h05);
        tick();
        web = 1'b0; web2 = 1'b0;
        push(1, "ro_readback", 8'h05);
        push(2, "rw_readback", 8'hAA);
        tick();
        ceb = 1'b0; ceb2 = 1'b0;

        // Load across the top-of-memory wrap with valid gaps.
        ld_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(10'h3FE, 11'd4, 2);
        rd_a("wrap_3fe", 10'h3FE);
        rd_a("wrap_3ff", 10'h3FF);
        rd_a("wrap_000", 10'h000);
        rd_a("wrap_001", 10'h001);
        rd_a("wrap_002", 10'h002);

        // Port B contention and same-address port A read during a load.
        ceb = 1'b1; web = 1'b0; ab = 10'h20;
        ceb2 = 1'b1; web2 = 1'b0; ab2 = 10'h20;
        push(1, "pre_b", 8'h20);
        push(2, "pre_b2", 8'h20);
        tick();
        ceb = 1'b0; ceb2 = 1'b0;
        ld_base = 10'h10; ld_count = 11'd2; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h5A;
        cea = 1'b1; aa = 10'h10;
        push(0, "same_cycle_old", model[10'h10]);
        ceb = 1'b1; web = 1'b1; ab = 10'h30; db = 8'hEE;
        ceb2 = 1'b1; web2 = 1'b1; ab2 = 10'h10; db2 = 8'hEE;
        push(1, "busy_b_hold", 8'h20);
        push(2, "busy_b2_hold", 8'h20);
        tick();
        model[10'h10] = 8'h5A;
        ld_data = 8'h6B;
        push(0, "next_read_new", 8'h5A);
        push(1, "busy_b_hold_last", 8'h20);
        push(2, "busy_b2_hold_last", 8'h20);
        tick();
        model[10'h11] = 8'h6B;
        ld_valid = 1'b0;
        check("contend_done", {31'd0, ld_done}, 32'd1);
        web = 1'b0; web2 = 1'b0; aa = 10'h11;
        push(0, "contend_11", 8'h6B);
        push(1, "after_b_30", 8'h30);
        push(2, "busy_write_dropped", 8'h5A);
        tick();
        cea = 1'b0; ceb = 1'b0; ceb2 = 1'b0;

        // Zero-count load.
        ld_base = 10'h40; ld_count = 11'd0; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("zero_busy", {31'd0, ld_busy}, 32'd1);
        check("zero_done_low", {31'd0, ld_done}, 32'd0);
        tick();
        check("zero_busy_end", {31'd0, ld_busy}, 32'd0);
        check("zero_done", {31'd0, ld_done}, 32'd1);
        rd_a("zero_mem_40", 10'h40);

        // ld_start during LOAD is ignored.
        ld_base = 10'h50; ld_count = 11'd2; ld_start = 1'b1;
        tick();
        ld_valid = 1'b1; ld_data = 8'h77; ld_base = 10'h60; ld_count = 11'd5;
        tick();
        model[10'h50] = 8'h77;
        ld_start = 1'b0; ld_data = 8'h88;
        tick();
        model[10'h51] = 8'h88;
        ld_valid = 1'b0;
        check("restart_ignored_busy", {31'd0, ld_busy}, 32'd0);
        check("restart_ignored_done", {31'd0, ld_done}, 32'd1);
        rd_a("restart_50", 10'h50);
        rd_a("restart_51", 10'h51);
        rd_a("restart_60", 10'h60);

        // Word offered with ld_start is not accepted.
        ld_base = 10'h70; ld_count = 11'd1; ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h99;
        tick();
        ld_start = 1'b0;
        check("start_valid_busy", {31'd0, ld_busy}, 32'd1);
        ld_data = 8'hAB;
        tick();
        model[10'h70] = 8'hAB;
        ld_valid = 1'b0;
        check("start_valid_done", {31'd0, ld_done}, 32'd1);
        rd_a("start_valid_70", 10'h70);
        rd_a("start_valid_71", 10'h71);

        // Reset after two of four words.
        ld_base = 10'h80; ld_count = 11'd4; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'hC1;
        tick();
        model[10'h80] = 8'hC1;
        ld_data = 8'hC2;
        tick();
        model[10'h81] = 8'hC2;
        ld_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", {31'd0, ld_busy}, 32'd0);
        check("midrst_done", {31'd0, ld_done}, 32'd0);
        check("midrst_ready", {31'd0, ld_ready}, 32'd0);
        check("midrst_qa", {24'd0, qa}, 32'd0);
        rd_a("midrst_80", 10'h80);
        rd_a("midrst_81", 10'h81);
        rd_a("midrst_82", 10'h82);
        ld_words = '{8'hD1, 8'hD2};
        do_load(10'h90, 11'd2, 1);
        rd_a("fresh_90", 10'h90);
        rd_a("fresh_91", 10'h91);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
